// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and sizing for the memory bus initiator
package mem_bus_pkg;
    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX) + 1;
    typedef enum logic [2:0] {
        IDLE, F_REQ, F_WAIT, EXEC, L_REQ, L_WAIT, S_REQ
    } mbi_state_t;
endpackage

// File: rtl/mem_rd_waiter.sv
// mem_rd_waiter: read-latency countdown shared by fetch and load paths
module mem_rd_waiter
    import mem_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? CNT_W'(RD_LAT - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign done = (cnt_q == '0);
endmodule

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: fetch/execute memory port initiator with one load or store per instruction
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jisr,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              exec_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rren,
    output logic              mem_wren,
    output logic              gp_we,
    output logic              E,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done
);
    mbi_state_t        state_q, state_d;
    logic              e_q, e_d, rren_q, rren_d, wren_q, wren_d;
    logic              irv_q, irv_d, lsd_q, lsd_d, wait_load, wait_done;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, ir_q, ir_d, lsr_q, lsr_d;

    mem_rd_waiter #(.RD_LAT(RD_LAT)) u_waiter (
        .clk  (clk),
        .rst  (rst),
        .load (wait_load),
        .done (wait_done)
    );

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        rren_d    = 1'b0;
        wren_d    = 1'b0;
        irv_d     = 1'b0;
        lsd_d     = 1'b0;
        wait_load = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ir_d      = ir_q;
        lsr_d     = lsr_q;
        if (jisr) begin
            state_d = IDLE;
            e_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fetch_req) begin
                    state_d = F_REQ;
                    addr_d  = pc_in;
                    rren_d  = 1'b1;
                end
                F_REQ: begin
                    wait_load = 1'b1;
                    state_d   = F_WAIT;
                end
                F_WAIT: if (wait_done) begin
                    ir_d    = mem_rdata;
                    irv_d   = 1'b1;
                    e_d     = 1'b1;
                    state_d = EXEC;
                end
                EXEC: if (ls_req) begin
                    addr_d  = ls_addr;
                    wdata_d = ls_we ? ls_wdata : wdata_q;
                    rren_d  = ~ls_we;
                    state_d = ls_we ? S_REQ : L_REQ;
                end else if (exec_done) begin
                    e_d     = 1'b0;
                    state_d = IDLE;
                end
                L_REQ: begin
                    wait_load = 1'b1;
                    state_d   = L_WAIT;
                end
                L_WAIT: if (wait_done) begin
                    lsr_d   = mem_rdata;
                    lsd_d   = 1'b1;
                    e_d     = 1'b0;
                    state_d = IDLE;
                end
                // first S_REQ cycle arms the strobe so an interrupt here cancels the store
                S_REQ: if (!wren_q) wren_d = 1'b1;
                else begin
                    lsd_d   = 1'b1;
                    e_d     = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= 1'b0;
            rren_q  <= 1'b0;
            wren_q  <= 1'b0;
            irv_q   <= 1'b0;
            lsd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            lsr_q   <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            rren_q  <= rren_d;
            wren_q  <= wren_d;
            irv_q   <= irv_d;
            lsd_q   <= lsd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            lsr_q   <= lsr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rren  = rren_q;
    assign mem_wren  = wren_q;
    assign gp_we     = wren_q;
    assign E         = e_q;
    assign ir_out    = ir_q;
    assign ir_valid  = irv_q;
    assign ls_rdata  = lsr_q;
    assign ls_done   = lsd_q;
endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator: two DUTs (read latency 1 and 3) against a transaction-level reference model
module tb_mem_bus_initiator;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst, jisr, fetch_req, ls_req, ls_we, exec_done, load_mem;
    logic [29:0] pc_in, ls_addr;
    logic [31:0] ls_wdata;

    logic [29:0] m_addr [2];
    logic [31:0] m_wdata [2], rdata [2], ir [2], lsr [2];
    logic        rren [2], wren [2], gpwe [2], e [2], irv [2], lsd [2];

    logic [31:0] mem [2][64];
    logic [31:0] pipe [2][4];
    logic [31:0] refmem [64];
    logic [31:0] ref_ir, ref_lsr;
    logic        ref_e;

    int n_cmp = 0, n_bad = 0, idx;
    int n_rr [2], n_wr [2], n_iv [2], n_ld [2], t_rr [2], t_wr [2], t_iv [2], t_ld [2];
    int n_both [2], n_gp [2], n_chg [2];
    logic        busy [2];
    logic [29:0] a_rr [2], a_wr [2], a_hold [2];
    logic [31:0] d_wr [2];

    always #5 clk = ~clk;

    mem_bus_initiator #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .jisr(jisr), .fetch_req(fetch_req), .pc_in(pc_in),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .exec_done(exec_done), .mem_rdata(rdata[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_rren(rren[0]), .mem_wren(wren[0]), .gp_we(gpwe[0]),
        .E(e[0]), .ir_out(ir[0]), .ir_valid(irv[0]), .ls_rdata(lsr[0]), .ls_done(lsd[0])
    );

    mem_bus_initiator #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .jisr(jisr), .fetch_req(fetch_req), .pc_in(pc_in),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .exec_done(exec_done), .mem_rdata(rdata[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_rren(rren[1]), .mem_wren(wren[1]), .gp_we(gpwe[1]),
        .E(e[1]), .ir_out(ir[1]), .ir_valid(irv[1]), .ls_rdata(lsr[1]), .ls_done(lsd[1])
    );

    // behavioural memory: read data valid exactly RD_LAT cycles after the strobe, garbage otherwise
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load_mem) for (int i = 0; i < 64; i++) mem[k][i] <= refmem[i];
            else if (wren[k]) mem[k][m_addr[k][5:0]] <= m_wdata[k];
            pipe[k][0] <= rren[k] ? mem[k][m_addr[k][5:0]] : BAD;
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end
    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][2];

    function automatic int lat(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    task automatic clr_obs;
        idx = 0;
        for (int k = 0; k < 2; k++) begin
            n_rr[k] = 0; n_wr[k] = 0; n_iv[k] = 0; n_ld[k] = 0;
            t_rr[k] = -1; t_wr[k] = -1; t_iv[k] = -1; t_ld[k] = -1;
            n_both[k] = 0; n_gp[k] = 0; n_chg[k] = 0; busy[k] = 1'b0;
            a_rr[k] = '0; a_wr[k] = '0; d_wr[k] = '0; a_hold[k] = '0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            idx++;
            for (int k = 0; k < 2; k++) begin
                if (rren[k]) begin n_rr[k]++; t_rr[k] = idx; a_rr[k] = m_addr[k]; end
                if (wren[k]) begin n_wr[k]++; t_wr[k] = idx; a_wr[k] = m_addr[k]; d_wr[k] = m_wdata[k]; end
                if (irv[k]) begin n_iv[k]++; t_iv[k] = idx; end
                if (lsd[k]) begin n_ld[k]++; t_ld[k] = idx; end
                if (rren[k] && wren[k]) n_both[k]++;
                if (gpwe[k] !== wren[k]) n_gp[k]++;
                if (rren[k] || wren[k]) begin busy[k] = 1'b1; a_hold[k] = m_addr[k]; end
                else if (busy[k] && m_addr[k] !== a_hold[k]) n_chg[k]++;
                if (irv[k] || lsd[k]) busy[k] = 1'b0;
            end
        end
    endtask

    task automatic idle_inputs;
        fetch_req = 0; ls_req = 0; ls_we = 0; exec_done = 0; jisr = 0;
        pc_in = 30'($urandom); ls_addr = 30'($urandom); ls_wdata = $urandom;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 64; i++) refmem[i] = $urandom;
        refmem[0] = 32'h240B_0007;
        rst = 1; load_mem = 1; idle_inputs();
        repeat (3) @(negedge clk);
        rst = 0; load_mem = 0;
        ref_ir = '0; ref_lsr = '0; ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({m_addr[k], m_wdata[k], rren[k], wren[k], gpwe[k], e[k], ir[k], irv[k], lsr[k], lsd[k]} !== '0) begin
                n_bad++;
                $display("FAIL reset[%0d]: addr=%h wdata=%h rren=%b wren=%b gp=%b E=%b ir=%h irv=%b lsr=%h lsd=%b, required all 0",
                    k, m_addr[k], m_wdata[k], rren[k], wren[k], gpwe[k], e[k], ir[k], irv[k], lsr[k], lsd[k]);
            end
        end
    endtask

    task automatic test_fetch(input logic [29:0] pc);
        clr_obs();
        fetch_req = 1; pc_in = pc;
        step(1);
        idle_inputs();
        step(7);
        ref_ir = refmem[pc[5:0]]; ref_e = 1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_rr[k] !== 1 || t_rr[k] !== 1 || a_rr[k] !== pc || n_wr[k] !== 0 || n_chg[k] !== 0) begin
                n_bad++;
                $display("FAIL fetch_strobe[%0d]: rren n=%0d t=%0d addr=%h wren n=%0d addr_changes=%0d, required 1/1/%h/0/0",
                    k, n_rr[k], t_rr[k], a_rr[k], n_wr[k], n_chg[k], pc);
            end
            n_cmp++;
            if (n_iv[k] !== 1 || t_iv[k] !== 2 + lat(k) || ir[k] !== ref_ir || e[k] !== ref_e) begin
                n_bad++;
                $display("FAIL fetch_ir[%0d]: irv n=%0d t=%0d ir=%h E=%b, required 1/%0d/%h/1",
                    k, n_iv[k], t_iv[k], ir[k], e[k], 2 + lat(k), ref_ir);
            end
        end
    endtask

    task automatic test_store(input logic [29:0] a, input logic [31:0] d, input logic ed);
        clr_obs();
        ls_req = 1; ls_we = 1; ls_addr = a; ls_wdata = d; exec_done = ed;
        step(1);
        idle_inputs();
        step(5);
        refmem[a[5:0]] = d; ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_wr[k] !== 1 || t_wr[k] !== 2 || a_wr[k] !== a || d_wr[k] !== d || n_gp[k] !== 0 || n_rr[k] !== 0) begin
                n_bad++;
                $display("FAIL store_strobe[%0d]: wren n=%0d t=%0d addr=%h data=%h gp_err=%0d rren n=%0d, required 1/2/%h/%h/0/0",
                    k, n_wr[k], t_wr[k], a_wr[k], d_wr[k], n_gp[k], n_rr[k], a, d);
            end
            n_cmp++;
            if (n_ld[k] !== 1 || t_ld[k] !== 3 || e[k] !== ref_e || mem[k][a[5:0]] !== refmem[a[5:0]]) begin
                n_bad++;
                $display("FAIL store_done[%0d]: lsd n=%0d t=%0d E=%b mem=%h, required 1/3/0/%h",
                    k, n_ld[k], t_ld[k], e[k], mem[k][a[5:0]], refmem[a[5:0]]);
            end
        end
    endtask

    task automatic test_load(input logic [29:0] a, input logic ed);
        clr_obs();
        ls_req = 1; ls_we = 0; ls_addr = a; exec_done = ed;
        step(1);
        idle_inputs();
        step(7);
        ref_lsr = refmem[a[5:0]]; ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_rr[k] !== 1 || t_rr[k] !== 1 || a_rr[k] !== a || n_wr[k] !== 0 || n_chg[k] !== 0) begin
                n_bad++;
                $display("FAIL load_strobe[%0d]: rren n=%0d t=%0d addr=%h wren n=%0d addr_changes=%0d, required 1/1/%h/0/0",
                    k, n_rr[k], t_rr[k], a_rr[k], n_wr[k], n_chg[k], a);
            end
            n_cmp++;
            if (n_ld[k] !== 1 || t_ld[k] !== 2 + lat(k) || lsr[k] !== ref_lsr || e[k] !== ref_e || n_iv[k] !== 0) begin
                n_bad++;
                $display("FAIL load_done[%0d]: lsd n=%0d t=%0d lsr=%h E=%b irv n=%0d, required 1/%0d/%h/0/0",
                    k, n_ld[k], t_ld[k], lsr[k], e[k], n_iv[k], 2 + lat(k), ref_lsr);
            end
        end
    endtask

    task automatic test_exec_done;
        clr_obs();
        exec_done = 1;
        step(1);
        idle_inputs();
        step(3);
        ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (e[k] !== ref_e || n_rr[k] + n_wr[k] + n_ld[k] + n_iv[k] !== 0) begin
                n_bad++;
                $display("FAIL exec_done[%0d]: E=%b strobes/pulses=%0d, required 0/0",
                    k, e[k], n_rr[k] + n_wr[k] + n_ld[k] + n_iv[k]);
            end
        end
    endtask

    task automatic test_jisr_fwait;
        logic [29:0] pc;
        pc = 30'($urandom_range(63));
        clr_obs();
        fetch_req = 1; pc_in = pc;
        step(2);
        idle_inputs();
        jisr = 1;
        step(1);
        jisr = 0;
        step(6);
        ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_iv[k] !== 0 || ir[k] !== ref_ir || e[k] !== ref_e || n_rr[k] !== 1) begin
                n_bad++;
                $display("FAIL jisr_fwait[%0d]: irv n=%0d ir=%h E=%b rren n=%0d, required 0/%h/0/1",
                    k, n_iv[k], ir[k], e[k], n_rr[k], ref_ir);
            end
        end
    endtask

    task automatic test_jisr_sreq;
        logic [29:0] a;
        a = 30'($urandom_range(63));
        clr_obs();
        ls_req = 1; ls_we = 1; ls_addr = a; ls_wdata = ~refmem[a[5:0]];
        step(1);
        idle_inputs();
        jisr = 1;
        step(1);
        jisr = 0;
        step(4);
        ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_wr[k] !== 0 || n_ld[k] !== 0 || e[k] !== ref_e || mem[k][a[5:0]] !== refmem[a[5:0]]) begin
                n_bad++;
                $display("FAIL jisr_sreq[%0d]: wren n=%0d lsd n=%0d E=%b mem=%h, required 0/0/0/%h",
                    k, n_wr[k], n_ld[k], e[k], mem[k][a[5:0]], refmem[a[5:0]]);
            end
        end
    endtask

    task automatic test_ignore(input logic in_exec);
        clr_obs();
        repeat (4) begin
            if (in_exec) begin fetch_req = 1; pc_in = 30'($urandom); end
            else begin ls_req = 1; ls_we = 1'($urandom); exec_done = 1; ls_addr = 30'($urandom); end
            step(1);
        end
        idle_inputs();
        step(3);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (n_rr[k] + n_wr[k] + n_ld[k] + n_iv[k] !== 0 || e[k] !== ref_e) begin
                n_bad++;
                $display("FAIL ignore_%s[%0d]: strobes/pulses=%0d E=%b, required 0/%b",
                    in_exec ? "exec" : "idle", k, n_rr[k] + n_wr[k] + n_ld[k] + n_iv[k], e[k], ref_e);
            end
        end
    endtask

    task automatic test_rst_midload;
        clr_obs();
        ls_req = 1; ls_we = 0; ls_addr = 30'($urandom_range(63));
        step(1);
        idle_inputs();
        step(1);
        rst = 1;
        step(1);
        rst = 0;
        ref_ir = '0; ref_lsr = '0; ref_e = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({m_addr[k], m_wdata[k], rren[k], wren[k], gpwe[k], e[k], ir[k], irv[k], lsr[k], lsd[k]} !== '0) begin
                n_bad++;
                $display("FAIL rst_midload[%0d]: addr=%h wdata=%h rren=%b wren=%b gp=%b E=%b ir=%h irv=%b lsr=%h lsd=%b, required all 0",
                    k, m_addr[k], m_wdata[k], rren[k], wren[k], gpwe[k], e[k], ir[k], irv[k], lsr[k], lsd[k]);
            end
        end
        step(5);
    endtask

    initial begin
        test_reset();
        test_fetch(30'd0);
        test_store(30'd5, 32'hDEAD_BEEF, 1'b0);
        test_fetch(30'($urandom_range(63)));
        test_load(30'd5, 1'b0);
        test_jisr_fwait();
        test_fetch(30'($urandom_range(63)));
        test_jisr_sreq();
        test_fetch(30'($urandom_range(63)));
        test_ignore(1'b1);
        test_exec_done();
        test_ignore(1'b0);
        repeat (8) begin
            test_fetch(30'($urandom_range(63)));
            case ($urandom_range(2))
                0: test_store(30'($urandom_range(63)), $urandom, 1'($urandom));
                1: test_load(30'($urandom_range(63)), 1'($urandom));
                default: test_exec_done();
            endcase
        end
        test_fetch(30'($urandom_range(63)));
        test_store(30'($urandom_range(63)), $urandom, 1'b1);
        test_fetch(30'($urandom_range(63)));
        test_load(30'd5, 1'b1);
        test_fetch(30'($urandom_range(63)));
        test_rst_midload();
        test_fetch(30'($urandom_range(63)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
